// File: rtl/dma_bus_arbiter_pkg.sv
// dma_bus_arbiter_pkg: shared bus widths and the arbiter state encoding, common with the DMA controller.
package dma_bus_arbiter_pkg;

    localparam int WORD_SIZE = 16;
    localparam int LEN_W     = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BR,
        DRAIN,
        GRANT,
        WAIT_IRQ
    } state_e;

    // States in which the abort timer runs.
    function automatic logic is_wait_state(state_e s);
        return s inside {WAIT_BR, DRAIN, GRANT, WAIT_IRQ};
    endfunction

endpackage

// File: rtl/dma_bus_arbiter_if.sv
// dma_bus_arbiter_if: CPU command, DMA handshake, memory-address and interrupt signals of the arbiter.
//   master: arbiter side (drives cmd_ready, startdma, address, length, BG, cpu_stall,
//           mem_address, irq_pending, timeout_err)
//   slave : CPU / DMA / memory side (drives the rest)
interface dma_bus_arbiter_if;
    import dma_bus_arbiter_pkg::*;

    logic                 cmd_valid;
    logic [WORD_SIZE-1:0] cmd_address;
    logic [LEN_W-1:0]     cmd_length;
    logic                 cmd_ready;
    logic                 startdma;
    logic [WORD_SIZE-1:0] address;
    logic [LEN_W-1:0]     length;
    logic                 BR;
    logic                 BG;
    logic                 cpu_mem_busy;
    logic                 cpu_stall;
    logic [WORD_SIZE-1:0] cpu_address;
    logic [WORD_SIZE-1:0] dma_address;
    logic [WORD_SIZE-1:0] mem_address;
    logic                 interrupt;
    logic                 irq_pending;
    logic                 irq_ack;
    logic                 timeout_err;

    modport master (
        input  cmd_valid, cmd_address, cmd_length, BR, cpu_mem_busy,
               cpu_address, dma_address, interrupt, irq_ack,
        output cmd_ready, startdma, address, length, BG, cpu_stall,
               mem_address, irq_pending, timeout_err
    );

    modport slave (
        output cmd_valid, cmd_address, cmd_length, BR, cpu_mem_busy,
               cpu_address, dma_address, interrupt, irq_ack,
        input  cmd_ready, startdma, address, length, BG, cpu_stall,
               mem_address, irq_pending, timeout_err
    );

endinterface

// File: rtl/dma_wait_timer.sv
// dma_wait_timer: per-state wait counter; done flags the cycle whose count would reach TIMEOUT.
//   clk, reset_n : clock, async active-low reset
//   clr          : zero the count (state change)
//   en           : count this cycle (wait state)
//   done         : the current cycle is the TIMEOUT-th cycle in the state
module dma_wait_timer #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;

    // Firing one count early makes the abort edge land exactly TIMEOUT cycles after state entry.
    assign done = en && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: issues a DMA command, hands the memory bus to the DMA on BR and latches its completion.
//   clk, reset_n : clock, async active-low reset
//   bus          : arbiter side of dma_bus_arbiter_if (CPU command, DMA handshake,
//                  memory address mux, interrupt/ack, timeout flag)
module dma_bus_arbiter
    import dma_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    dma_bus_arbiter_if.master bus
);

    state_e               state_q, state_d;
    logic [WORD_SIZE-1:0] address_q, address_d;
    logic [LEN_W-1:0]     length_q, length_d;
    logic                 irq_pending_q, irq_pending_d;
    logic                 timeout_err_q, timeout_err_d;
    logic                 tmo_done;
    logic                 bg;

    dma_wait_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (state_d != state_q),
        .en     (is_wait_state(state_q)),
        .done   (tmo_done)
    );

    always_comb begin
        state_d       = state_q;
        address_d     = address_q;
        length_d      = length_q;
        timeout_err_d = timeout_err_q;
        // A completion in the same cycle as an ack must not be lost.
        irq_pending_d = (state_q == WAIT_IRQ && bus.interrupt) ? 1'b1 :
                        bus.irq_ack ? 1'b0 : irq_pending_q;
        case (state_q)
            IDLE:     if (bus.cmd_valid) begin
                          state_d       = START;
                          address_d     = bus.cmd_address;
                          length_d      = bus.cmd_length;
                          timeout_err_d = 1'b0;
                      end
            START:    state_d = WAIT_BR;
            WAIT_BR:  if (bus.BR) state_d = DRAIN;
            DRAIN:    if (!bus.cpu_mem_busy) state_d = GRANT;
            GRANT:    if (!bus.BR) state_d = WAIT_IRQ;
            WAIT_IRQ: if (bus.interrupt) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        // Real progress on the last allowed cycle beats the abort.
        if (tmo_done && state_d == state_q) begin
            state_d       = IDLE;
            timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            address_q     <= '0;
            length_q      <= '0;
            irq_pending_q <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            address_q     <= address_d;
            length_q      <= length_d;
            irq_pending_q <= irq_pending_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bg              = (state_q == GRANT);
    assign bus.BG          = bg;
    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.startdma    = (state_q == START);
    assign bus.cpu_stall   = (state_q == DRAIN) || (state_q == GRANT);
    assign bus.address     = address_q;
    assign bus.length      = length_q;
    assign bus.irq_pending = irq_pending_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.mem_address = bg ? bus.dma_address : bus.cpu_address;

endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- CPU-side counterpart of the DMA controller: issues the DMA command and answers the DMA bus request.
- Sequence: accepts one CPU command (address, length), pulses startdma, and waits for BR. It then drains any in-flight CPU memory access, grants BG and stalls the CPU until BR drops, then latches the DMA interrupt for the CPU.
- Owns the memory-address mux between CPU and DMA.
- Sits between the CPU datapath, the DMA controller and memory.

Parameters:
- WORD_SIZE, 16, address/data width.
- LEN_W, 4, width of the length field.
- TIMEOUT, 64, max cycles spent in any one wait state before aborting.
- CNT_W, 7, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  CPU requests a DMA transfer (sampled when cmd_ready=1)
- cmd_address  in  WORD_SIZE  destination base address
- cmd_length  in  LEN_W  transfer length
- cmd_ready  out  1  arbiter idle, command accepted this cycle if cmd_valid
- startdma  out  1  one-cycle pulse to DMA
- address  out  WORD_SIZE  latched base address to DMA, held until next accept
- length  out  LEN_W  latched length to DMA, held until next accept
- BR  in  1  bus request from DMA
- BG  out  1  bus grant to DMA
- cpu_mem_busy  in  1  CPU memory access in flight
- cpu_stall  out  1  CPU must not start a memory access
- cpu_address  in  WORD_SIZE  CPU memory address
- dma_address  in  WORD_SIZE  DMA o_address
- mem_address  out  WORD_SIZE  address driven to memory
- interrupt  in  1  DMA completion pulse
- irq_pending  out  1  sticky completion flag to CPU
- irq_ack  in  1  CPU clears irq_pending
- timeout_err  out  1  sticky abort flag

Behaviour:
- Reset (async, reset_n=0) clears these immediately: state=IDLE, counter=0, address=0, length=0, startdma=0, BG=0, cpu_stall=0, irq_pending=0, timeout_err=0.
- Reset mid-transfer behaves the same way; BG drops asynchronously.
- All outputs except mem_address and cmd_ready are registered, or Moore decodes of the state register.
- States and transitions:
  - IDLE: cmd_ready=1. cmd_valid → latch cmd_address/cmd_length, clear timeout_err, go START.
  - START: startdma=1 for exactly this cycle → WAIT_BR.
  - WAIT_BR: BR=1 → DRAIN.
  - DRAIN: cpu_stall=1. cpu_mem_busy=0 → GRANT. If BR=1 and cpu_mem_busy=0 in the same cycle, still go via DRAIN; the minimum BR-to-BG latency is 2 cycles.
  - GRANT: BG=1, cpu_stall=1. BR=0 → WAIT_IRQ, so BG falls one cycle after BR falls.
  - WAIT_IRQ: BG=0, cpu_stall=0. interrupt=1 → IDLE, set irq_pending.
- Timeout:
  - The counter clears on every state change.
  - It increments each cycle in WAIT_BR, DRAIN, GRANT and WAIT_IRQ.
  - On reaching TIMEOUT: set timeout_err, go IDLE, BG=0 next cycle, cpu_stall=0.
  - No saturation is needed because the count never exceeds TIMEOUT.
- irq_pending:
  - Set on interrupt in WAIT_IRQ; cleared by irq_ack.
  - Simultaneous set and ack: set wins.
  - interrupt outside WAIT_IRQ is ignored.
- cmd_ready = (state==IDLE), combinational. cmd_valid while not idle is ignored and not queued.
- mem_address = BG ? dma_address : cpu_address, combinational.
- cmd_length is forwarded unmodified; 0 is legal.
- A new command may be accepted while irq_pending=1.

Decomposition:
- Shared package: state encoding (IDLE, START, WAIT_BR, DRAIN, GRANT, WAIT_IRQ) and the WORD_SIZE constant, common with the DMA controller.
- One natural sub-module, dma_wait_timer: the counter with clear/enable inputs and a done output at TIMEOUT.
- The address mux stays inline.

Test Plan:
- Normal transfer:
  - Stimulus: cmd_valid with address=0x0010, length=12. Model DMA raises BR 1 cycle after startdma, holds it 12 cycles, then pulses interrupt 1 cycle after BG falls.
  - Response: startdma high exactly 1 cycle; BG high 2 cycles after BR rises; mem_address=dma_address while BG=1; BG low 1 cycle after BR falls; irq_pending=1; cmd_ready=1 afterward.
- CPU drain: cpu_mem_busy=1 for 3 cycles after BR rises → cpu_stall=1 from DRAIN entry; BG rises only on the cycle after cpu_mem_busy falls.
- Command while busy: second cmd_valid (address=0x0040) during GRANT → ignored; address output stays 0x0010; no second startdma.
- Timeout: BR never asserted → timeout_err=1 exactly TIMEOUT cycles after WAIT_BR entry; state returns to IDLE; BG stays 0; the next accepted command clears timeout_err.
- Interrupt/ack race: irq_ack asserted in the same cycle as interrupt → irq_pending=1; a later irq_ack alone → irq_pending=0.
- Async reset: reset_n=0 mid-GRANT (not on a clock edge) → BG=0 and cpu_stall=0 immediately; after release, cmd_ready=1 and irq_pending=0.
